// File: rtl/bp_fe_ras_pkg.sv
// rtl/bp_fe_ras_pkg.sv - RAS controller types, opcode constants and call/return decode
`define BP_FE_RAS_CKPT_S(name, idx_w) typedef struct packed { logic [(idx_w)-1:0] tos; logic [(idx_w):0] count; } name;

package bp_fe_ras_pkg;

    localparam int ras_idx_width_c = 2;

    localparam logic [6:0] op_jal_c  = 7'b1101111;
    localparam logic [6:0] op_jalr_c = 7'b1100111;
    localparam logic [4:0] link_x1_c = 5'd1;
    localparam logic [4:0] link_x5_c = 5'd5;

    typedef enum logic [1:0] {
        e_ras_none,
        e_ras_push,
        e_ras_pop,
        e_ras_poppush
    } ras_op_e;

    typedef enum logic {
        e_run,
        e_restore
    } ctrl_state_e;

    `BP_FE_RAS_CKPT_S(ras_ckpt_s, ras_idx_width_c)

    function automatic logic is_link(input logic [4:0] r);
        return (r == link_x1_c) || (r == link_x5_c);
    endfunction

    // JALR with two different link registers is a coroutine swap: pop then push.
    function automatic ras_op_e decode_ras_op(input logic [6:0] opcode,
                                              input logic [4:0] rd,
                                              input logic [4:0] rs1);
        ras_op_e op;
        op = e_ras_none;
        if (opcode == op_jal_c) begin
            if (is_link(rd)) op = e_ras_push;
        end else if (opcode == op_jalr_c) begin
            if (is_link(rd) && is_link(rs1) && (rd != rs1)) op = e_ras_poppush;
            else if (is_link(rd))                           op = e_ras_push;
            else if (is_link(rs1))                          op = e_ras_pop;
        end
        return op;
    endfunction

endpackage

// File: rtl/bp_fe_ras_ctrl_if.sv
// rtl/bp_fe_ras_ctrl_if.sv - fetch/branch-side signal bundle for the RAS controller
interface bp_fe_ras_ctrl_if #(
    parameter int eaddr_width_p = 32,
    parameter int instr_width_p = 32,
    parameter int ckpt_els_p    = 4
);
    localparam int ckpt_id_width_lp = $clog2(ckpt_els_p);

    logic                        instr_v_i;
    logic [instr_width_p-1:0]    instr_i;
    logic [eaddr_width_p-1:0]    pc_i;
    logic                        instr_ready_o;
    logic [eaddr_width_p-1:0]    pred_pc_o;
    logic                        pred_v_o;
    logic                        ckpt_v_i;
    logic                        ckpt_ready_o;
    logic [ckpt_id_width_lp-1:0] ckpt_id_o;
    logic                        commit_v_i;
    logic                        restore_v_i;
    logic [ckpt_id_width_lp-1:0] restore_id_i;
    logic                        flush_all_i;

    modport master (
        output instr_v_i, instr_i, pc_i, ckpt_v_i, commit_v_i,
               restore_v_i, restore_id_i, flush_all_i,
        input  instr_ready_o, pred_pc_o, pred_v_o, ckpt_ready_o, ckpt_id_o
    );

    modport slave (
        input  instr_v_i, instr_i, pc_i, ckpt_v_i, commit_v_i,
               restore_v_i, restore_id_i, flush_all_i,
        output instr_ready_o, pred_pc_o, pred_v_o, ckpt_ready_o, ckpt_id_o
    );

endinterface

// File: rtl/bp_fe_ras_mem.sv
// rtl/bp_fe_ras_mem.sv - RAS storage: one synchronous write port, one asynchronous read port
module bp_fe_ras_mem #(
    parameter int eaddr_width_p   = 32,
    parameter int ras_idx_width_p = 2
) (
    input  logic                       clk_i,
    input  logic                       w_v_i,
    input  logic [ras_idx_width_p-1:0] w_addr_i,
    input  logic [eaddr_width_p-1:0]   w_data_i,
    input  logic [ras_idx_width_p-1:0] r_addr_i,
    output logic [eaddr_width_p-1:0]   r_data_o
);

    logic [eaddr_width_p-1:0] mem_q [2**ras_idx_width_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) mem_q[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_ras_ctrl.sv
// rtl/bp_fe_ras_ctrl.sv - RAS controller: call/return decode, TOS/count tracking, per-branch checkpoints
module bp_fe_ras_ctrl
    import bp_fe_ras_pkg::*;
#(
    parameter int eaddr_width_p   = 32,
    parameter int instr_width_p   = 32,
    parameter int ras_idx_width_p = 2,
    parameter int ckpt_els_p      = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    bp_fe_ras_ctrl_if.slave    bus
);

    localparam int depth_lp     = 1 << ras_idx_width_p;
    localparam int ckpt_id_w_lp = $clog2(ckpt_els_p);

    `BP_FE_RAS_CKPT_S(ckpt_entry_s, ras_idx_width_p)

    typedef logic [ras_idx_width_p-1:0] idx_t;
    typedef logic [ras_idx_width_p:0]   cnt_t;
    typedef logic [ckpt_id_w_lp-1:0]    cid_t;
    typedef logic [ckpt_id_w_lp:0]      ccnt_t;

    localparam cnt_t  depth_c     = cnt_t'(depth_lp);
    localparam ccnt_t ckpt_full_c = ccnt_t'(ckpt_els_p);

    ctrl_state_e state_q, state_d;
    idx_t        tos_q, tos_d;
    cnt_t        count_q, count_d;
    cid_t        head_q, head_d;
    cid_t        tail_q, tail_d;
    ccnt_t       ckpt_cnt_q, ckpt_cnt_d;
    ckpt_entry_s snap_q [ckpt_els_p];

    ras_op_e                  op;
    logic                     accept;
    logic                     has_entry;
    logic                     ckpt_take;
    logic                     commit_take;
    logic                     restore_take;
    idx_t                     tos_upd;
    cnt_t                     count_upd;
    logic                     mem_w_v;
    idx_t                     mem_w_addr;
    logic [eaddr_width_p-1:0] mem_r_data;
    logic [eaddr_width_p-1:0] ret_addr;
    ckpt_entry_s              restore_snap;
    cid_t                     restore_rel;
    logic                     unused_instr_bits;

    assign unused_instr_bits = ^{bus.instr_i[instr_width_p-1:20], bus.instr_i[14:12]};

    assign op        = decode_ras_op(bus.instr_i[6:0], bus.instr_i[11:7], bus.instr_i[19:15]);
    assign has_entry = (count_q != '0);
    assign ret_addr  = bus.pc_i + eaddr_width_p'(4);

    assign bus.instr_ready_o = (state_q == e_run) & ~bus.restore_v_i & ~bus.flush_all_i;
    assign bus.ckpt_ready_o  = (ckpt_cnt_q != ckpt_full_c) & (state_q == e_run)
                             & ~bus.restore_v_i & ~bus.flush_all_i;
    assign bus.ckpt_id_o     = tail_q;

    assign accept       = bus.instr_v_i & bus.instr_ready_o;
    assign ckpt_take    = bus.ckpt_v_i & bus.ckpt_ready_o;
    assign commit_take  = bus.commit_v_i & (ckpt_cnt_q != '0);
    assign restore_take = bus.restore_v_i & (state_q == e_run) & ~bus.flush_all_i;

    assign bus.pred_v_o  = accept & ((op == e_ras_pop) | (op == e_ras_poppush)) & has_entry;
    assign bus.pred_pc_o = bus.pred_v_o ? mem_r_data : '0;

    // Post-instruction stack pointers; also the values captured by a same-cycle checkpoint.
    always_comb begin
        tos_upd    = tos_q;
        count_upd  = count_q;
        mem_w_v    = 1'b0;
        mem_w_addr = tos_q;
        if (accept) begin
            unique case (op)
                e_ras_push: begin
                    mem_w_v    = 1'b1;
                    mem_w_addr = tos_q + idx_t'(1);
                    tos_upd    = tos_q + idx_t'(1);
                    if (count_q != depth_c) count_upd = count_q + cnt_t'(1);
                end
                e_ras_pop: begin
                    if (has_entry) begin
                        tos_upd   = tos_q - idx_t'(1);
                        count_upd = count_q - cnt_t'(1);
                    end
                end
                e_ras_poppush: begin
                    mem_w_v = 1'b1;
                    if (!has_entry) count_upd = cnt_t'(1);
                end
                default: ;
            endcase
        end
    end

    assign restore_snap = snap_q[bus.restore_id_i];
    assign restore_rel  = bus.restore_id_i - head_q;

    always_comb begin
        state_d    = state_q;
        tos_d      = tos_upd;
        count_d    = count_upd;
        head_d     = head_q;
        tail_d     = tail_q;
        ckpt_cnt_d = ckpt_cnt_q;
        if (commit_take) begin
            head_d     = head_q + cid_t'(1);
            ckpt_cnt_d = ckpt_cnt_q - ccnt_t'(1);
        end
        if (bus.flush_all_i) begin
            state_d    = e_run;
            tos_d      = '0;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            ckpt_cnt_d = '0;
        end else if (restore_take) begin
            // The restored checkpoint stays live; everything younger is discarded.
            state_d    = e_restore;
            tos_d      = restore_snap.tos;
            count_d    = restore_snap.count;
            tail_d     = bus.restore_id_i + cid_t'(1);
            ckpt_cnt_d = ccnt_t'(restore_rel) + ccnt_t'(1) - ccnt_t'(commit_take);
        end else begin
            state_d = e_run;
            if (ckpt_take) begin
                tail_d     = tail_q + cid_t'(1);
                ckpt_cnt_d = ckpt_cnt_d + ccnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_run;
            tos_q      <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            ckpt_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tos_q      <= tos_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            ckpt_cnt_q <= ckpt_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ckpt_take) snap_q[tail_q] <= '{tos: tos_upd, count: count_upd};
    end

    bp_fe_ras_mem #(
        .eaddr_width_p  (eaddr_width_p),
        .ras_idx_width_p(ras_idx_width_p)
    ) u_mem (
        .clk_i   (clk_i),
        .w_v_i   (mem_w_v),
        .w_addr_i(mem_w_addr),
        .w_data_i(ret_addr),
        .r_addr_i(tos_q),
        .r_data_o(mem_r_data)
    );

endmodule

// File: doc/bp_fe_ras_ctrl.md
Name: bp_fe_ras_ctrl

Overview:
Controller for the front-end return address stack (RAS). Decodes each fetched instruction as call/return/other and sequences push/pop on a circular RAS storage array. Tracks top-of-stack (TOS) and occupancy, and checkpoints the {TOS, count} pair per in-flight branch so a redirect can restore it. Sits beside fetch; feeds the return-target prediction to next-PC select.

Parameters:
eaddr_width_p, 32, PC / return-address width
instr_width_p, 32, instruction width (RV32/64 encoding; only bits [19:0] are decoded)
ras_idx_width_p, 2, log2 RAS depth (depth = 4)
ckpt_els_p, 4, checkpoint queue entries (power of 2)

Ports:
clk_i  in  1  clock
reset_i  in  1  reset, asynchronous, active-high
instr_v_i  in  1  fetched instruction valid
instr_i  in  instr_width_p  fetched instruction
pc_i  in  eaddr_width_p  PC of instr_i
instr_ready_o  out  1  controller accepts instruction this cycle
pred_pc_o  out  eaddr_width_p  predicted return target
pred_v_o  out  1  pred_pc_o valid
ckpt_v_i  in  1  take checkpoint (branch issued)
ckpt_ready_o  out  1  checkpoint slot available
ckpt_id_o  out  log2(ckpt_els_p)  id assigned to the checkpoint taken this cycle
commit_v_i  in  1  retire oldest checkpoint
restore_v_i  in  1  mispredict redirect
restore_id_i  in  log2(ckpt_els_p)  checkpoint to restore
flush_all_i  in  1  empty RAS and checkpoint queue (sync)

Behaviour:
- Reset (async): tos_r=0, count_r=0, ckpt head=tail=0, state RUN; pred_v_o=0, pred_pc_o=0, ckpt_id_o=0, instr_ready_o=1, ckpt_ready_o=1.
- Decode (link = x1 or x5): call = JAL(1101111) or JALR(1100111) with rd=link; ret = JALR with rs1=link and rd!=link; JALR with rd=link, rs1=link, rs1!=rd = pop-then-push; everything else no-op.
- Accept = instr_v_i & instr_ready_o. instr_ready_o = (state==RUN) & ~restore_v_i & ~flush_all_i.
- Ret: pred_pc_o = mem[tos_r] combinationally in same cycle; pred_v_o = accept & ret & count_r!=0. Empty: pred_v_o=0, pred_pc_o=0, no state change. On pop: tos_r-1 mod depth, count_r-1.
- Call: write mem[tos_r+1] = pc_i+4 (mod 2^eaddr_width_p), tos_r+1 mod depth, count_r saturates at depth (overflow overwrites oldest, no error).
- Pop-then-push: predict mem[tos_r] (if count_r!=0), write pc_i+4 into mem[tos_r]; tos_r unchanged; count_r=max(count_r,1).
- Checkpoint: ckpt_ready_o = queue not full & state RUN & ~restore_v_i & ~flush_all_i. On ckpt_v_i & ckpt_ready_o: store post-update {tos,count} (includes same-cycle call/ret) at tail; ckpt_id_o = tail; tail+1 mod ckpt_els_p.
- Commit: head+1; ignored when queue empty. Commit and checkpoint in the same cycle are both honoured.
- Restore: restore_v_i in RUN -> tos/count <= snapshot[restore_id_i]; tail <= restore_id_i+1 (younger checkpoints discarded, restored one kept); same-cycle instr/ckpt dropped; same-cycle commit honoured. Next state RESTORE: one bubble cycle, instr_ready_o=0, ckpt_ready_o=0, then RUN. Memory contents not restored. restore_id_i not live: undefined, flagged by bench assertion.
- flush_all_i: priority over everything; next cycle tos=count=0, queue empty, state RUN.
- Priority: flush_all_i > restore_v_i > instruction/checkpoint.

Decomposition:
- bp_fe_ras_pkg: opcode constants (JAL, JALR), link-register constants, ras_op_e {e_ras_none, e_ras_push, e_ras_pop, e_ras_poppush}, ctrl_state_e {e_run, e_restore}, ras_ckpt_s {tos, count} (parameterised widths via macro).
- Sub-module bp_fe_ras_mem: 2^ras_idx_width_p x eaddr_width_p array, 1 sync write port, 1 async read port; controller owns all pointers.

Test Plan:
- Fill/drain: calls at pc 0x100,0x200,0x300,0x400, then 5 rets -> pred 0x404,0x304,0x204,0x104 with pred_v_o=1, fifth pred_v_o=0, count_r=0.
- Overflow: calls at 0x10..0x60 step 0x10, then 5 rets -> pred 0x64,0x54,0x44,0x34, then pred_v_o=0.
- Restore: call 0x1000; ckpt (id0, count=1); call 0x2000; ret (0x2004); ret (0x1004); restore id0 -> next cycle instr_ready_o=0; then ret -> pred 0x1004.
- Queue full: 4 checkpoints, no commit -> ids 0,1,2,3, ckpt_ready_o=0; commit -> ckpt_ready_o=1, next id 0.
- Simultaneous: restore id0 same cycle as call 0x3000 and ckpt_v_i -> call and ckpt dropped, count=snapshot, tail=1.
- Reset mid-operation: after 3 calls assert reset_i between clock edges -> outputs reset immediately; after release ret gives pred_v_o=0; flush_all_i gives the same result synchronously.
